// File: rtl/arb_defs.sv
// Shared constants for the four-way bus arbiter: requester count, select width,
// FSM state encoding and the post-reset round-robin pointer.
package arb_defs;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Pointer starts at the last slot so requester 0 wins the first arbitration.
  localparam logic [SEL_W-1:0] LAST_PTR_RST = 2'd3;
endpackage

// File: rtl/mux4.sv
// Plain 4:1 data multiplexer shared by the bus masters.
module mux4 #(
  parameter int W = 32
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [1:0]   sel,
  output logic [W-1:0] out
);
  always_comb begin
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end
endmodule

// File: rtl/rr_pick4.sv
// Rotating priority encoder: returns the first asserted request found when
// scanning from 'start' upward, wrapping modulo 4.
module rr_pick4
  import arb_defs::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  always_comb begin
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = start + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter_4.sv
// Round-robin owner-holds arbiter for one shared 32-bit write port.
// Define ARB_TIMEOUT_EN to add the MAX_HOLD watchdog that forces preemption.
module bus_arbiter_4
  import arb_defs::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [DATA_W-1:0] wdata3,
  output logic [N_REQ-1:0]  gnt,
  output logic [SEL_W-1:0]  sel,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              preempt
);
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("MAX_HOLD must be at least 2");
  end

  state_t           state, state_nx;
  logic [N_REQ-1:0] gnt_nx;
  logic [SEL_W-1:0] sel_nx, last_ptr, last_ptr_nx, start;
  logic             preempt_nx, new_grant, timeout;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic [DATA_W-1:0] mux_out;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  logic [CNT_W-1:0] hold_cnt;

  assign timeout = (state == ST_GRANT) && req[sel] && (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst)                    hold_cnt <= '0;
    else if (new_grant)         hold_cnt <= '0;
    else if (state == ST_GRANT) hold_cnt <= hold_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // IDLE searches past the last owner; a release searches past the current one.
  assign start = (state == ST_IDLE) ? last_ptr + 1'b1 : sel + 1'b1;

  rr_pick4 u_pick (
    .req   (req),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    sel_nx      = sel;
    last_ptr_nx = last_ptr;
    preempt_nx  = 1'b0;
    new_grant   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nx  = ST_GRANT;
          gnt_nx    = N_REQ'(1) << pick_idx;
          sel_nx    = pick_idx;
          new_grant = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!req[sel] || timeout) begin
          last_ptr_nx = sel;
          preempt_nx  = timeout;
          if (pick_found) begin
            gnt_nx    = N_REQ'(1) << pick_idx;
            sel_nx    = pick_idx;
            new_grant = 1'b1;
          end else begin
            state_nx = ST_IDLE;
            gnt_nx   = '0;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      sel      <= '0;
      last_ptr <= LAST_PTR_RST;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      sel      <= sel_nx;
      last_ptr <= last_ptr_nx;
      preempt  <= preempt_nx;
    end
  end

  assign bus_valid = (state == ST_GRANT);

  mux4 #(.W(DATA_W)) u_mux (
    .in0 (wdata0),
    .in1 (wdata1),
    .in2 (wdata2),
    .in3 (wdata3),
    .sel (sel),
    .out (mux_out)
  );

  assign bus_data = bus_valid ? mux_out : '0;
endmodule

// File: tb/tb_bus_arbiter_4.sv
// Scoreboard bench for bus_arbiter_4: the driver queues the hand-computed
// expected outputs for each edge, a monitor pops and compares after the edge.
module tb_bus_arbiter_4;
  logic        clk, rst;
  logic [3:0]  req;
  logic [31:0] wdata0, wdata1, wdata2, wdata3;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        bus_valid, preempt;
  logic [31:0] bus_data;

  typedef struct {
    string       name;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        valid;
    logic [31:0] data;
    logic        pe;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] wd [4];

  bus_arbiter_4 #(.DATA_W(32), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .wdata2    (wdata2),
    .wdata3    (wdata3),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .preempt   (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: each queued expectation belongs to the edge just taken.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (gnt === e.gnt && sel === e.sel && bus_valid === e.valid &&
            bus_data === e.data && preempt === e.pe)
          n_pass++;
        else
          $display("FAIL %s: got gnt=%b sel=%0d valid=%b data=%h preempt=%b, want gnt=%b sel=%0d valid=%b data=%h preempt=%b",
                   e.name, gnt, sel, bus_valid, bus_data, preempt,
                   e.gnt, e.sel, e.valid, e.data, e.pe);
      end
    end
  end

  task automatic cyc(input string name, input logic r, input logic [3:0] rq,
                     input logic [3:0] g, input logic [1:0] s, input logic pe);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    e.name  = name;
    e.gnt   = g;
    e.sel   = s;
    e.valid = (g != 4'b0000);
    e.data  = e.valid ? wd[s] : 32'h0;
    e.pe    = pe;
    exp_q.push_back(e);
  endtask

  initial begin
    int owner;
    logic pe;
    wd[0] = 32'hAAAA_0000; wd[1] = 32'hBBBB_0001;
    wd[2] = 32'hCCCC_0002; wd[3] = 32'hDDDD_0003;
    wdata0 = wd[0]; wdata1 = wd[1]; wdata2 = wd[2]; wdata3 = wd[3];
    rst = 1'b1;
    req = 4'b0000;

    cyc("reset0", 1, 4'b0000, 4'b0000, 2'd0, 0);
    cyc("reset1", 1, 4'b0000, 4'b0000, 2'd0, 0);

    // Single requester grant and release
    cyc("grant0",   0, 4'b0001, 4'b0001, 2'd0, 0);
    cyc("release0", 0, 4'b0000, 4'b0000, 2'd0, 0);

    // Full rotation 0,1,2,3,0 with back-to-back handoff
    cyc("rr_rst", 1, 4'b0000, 4'b0000, 2'd0, 0);
    cyc("rr_o0a", 0, 4'b1111, 4'b0001, 2'd0, 0);
    cyc("rr_o0b", 0, 4'b1111, 4'b0001, 2'd0, 0);
    cyc("rr_o0c", 0, 4'b1111, 4'b0001, 2'd0, 0);
    cyc("rr_o1a", 0, 4'b1110, 4'b0010, 2'd1, 0);
    cyc("rr_o1b", 0, 4'b1111, 4'b0010, 2'd1, 0);
    cyc("rr_o1c", 0, 4'b1111, 4'b0010, 2'd1, 0);
    cyc("rr_o2a", 0, 4'b1101, 4'b0100, 2'd2, 0);
    cyc("rr_o2b", 0, 4'b1101, 4'b0100, 2'd2, 0);
    cyc("rr_o2c", 0, 4'b1101, 4'b0100, 2'd2, 0);
    cyc("rr_o3a", 0, 4'b1011, 4'b1000, 2'd3, 0);
    cyc("rr_o3b", 0, 4'b1011, 4'b1000, 2'd3, 0);
    cyc("rr_o3c", 0, 4'b1011, 4'b1000, 2'd3, 0);
    cyc("rr_o0w", 0, 4'b0111, 4'b0001, 2'd0, 0);
    cyc("rr_idle", 0, 4'b0000, 4'b0000, 2'd0, 0);

    // Owner 2 with req0 pending: handoff wraps past 3 to 0, skipping 1
    cyc("wrap_o2",  0, 4'b0100, 4'b0100, 2'd2, 0);
    cyc("wrap_hold", 0, 4'b0101, 4'b0100, 2'd2, 0);
    cyc("wrap_to0", 0, 4'b0001, 4'b0001, 2'd0, 0);
    cyc("back_o2",  0, 4'b0100, 4'b0100, 2'd2, 0);

    // Reset mid-grant, then RR restarts with req0 priority
    cyc("rst_mid",   1, 4'b1010, 4'b0000, 2'd0, 0);
    cyc("post_rst1", 0, 4'b1010, 4'b0010, 2'd1, 0);
    cyc("sel_holds", 0, 4'b0000, 4'b0000, 2'd1, 0);

    // req=0011 held: watchdog rotates owners, otherwise owner 0 holds
    cyc("hold_rst", 1, 4'b0000, 4'b0000, 2'd0, 0);
    for (int k = 1; k <= 110; k++) begin
`ifdef ARB_TIMEOUT_EN
      owner = ((k - 1) / 4) % 2;
      pe    = (k > 1) && ((k - 1) % 4 == 0);
`else
      owner = 0;
      pe    = 1'b0;
`endif
      cyc("hold_0011", 0, 4'b0011, 4'(1 << owner), 2'(owner), pe);
    end

    // Sole requester: regranted on every watchdog expiry
    cyc("solo_rst", 1, 4'b0000, 4'b0000, 2'd0, 0);
    for (int k = 1; k <= 13; k++) begin
`ifdef ARB_TIMEOUT_EN
      pe = (k > 1) && ((k - 1) % 4 == 0);
`else
      pe = 1'b0;
`endif
      cyc("solo_0001", 0, 4'b0001, 4'b0001, 2'd0, pe);
    end
    cyc("solo_rel", 0, 4'b0000, 4'b0000, 2'd0, 0);

    @(posedge clk);
    #5;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_4.md
# bus_arbiter_4

Round-robin arbiter that shares one 32-bit datapath port between four requesters. It drives the 2-bit select of the shared 4:1 data multiplexer and a one-hot grant vector. It sits between the four masters (IF, MEM, DMA, debug) and the single memory/bus write port in the multicycle CPU. Ownership is held for as long as the owner keeps its request asserted, with an optional hold-time watchdog that forces preemption.

## Interface
Parameters:
- DATA_W, 32, width of each requester data word and of bus_data
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership (only with watchdog compiled in; must be ≥2)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  4  request per requester; the requester holds it high for the whole transfer
- wdata0..wdata3  in  DATA_W each  requester data words
- gnt  out  4  one-hot grant, registered
- sel  out  2  select index of the current owner, registered; drives the shared mux
- bus_valid  out  1  high while a grant is active
- bus_data  out  DATA_W  wdata[sel] when bus_valid, else 0; combinational from registered sel
- preempt  out  1  one-cycle pulse in the cycle after a watchdog-forced release

## Operation
- Two states: IDLE (no owner) and GRANT (one owner).
- Arbitration order is round-robin. Search starts at last_ptr+1 mod 4, where last_ptr is the index of the most recent owner. The first requester found with req high wins.
- IDLE → GRANT: any req high at the clock edge. The winner's gnt bit and sel are loaded, and last_ptr is updated on release.
- GRANT, owner req still high: hold. gnt and sel are unchanged.
- GRANT, owner req low at the edge: release.
  - If another req is high at that edge, hand off directly to the next requester in RR order from sel+1. State stays GRANT, with no bubble cycle.
  - Otherwise go to IDLE; gnt is 0 and sel holds its last value.
- Requests from non-owners never disturb the current grant.
- Simultaneous requests: RR order only. After reset, last_ptr=3, so req0 has top priority.
- A req pulse that drops before being granted is lost; it is not latched.
- rst asserted at any time, including mid-grant:
  - next edge: state=IDLE, gnt=0, sel=0, last_ptr=3, hold counter=0, preempt=0.
  - The owner's transfer is abandoned.
- Reset values of the outputs: gnt=4'b0000, sel=2'b00, bus_valid=0, bus_data=0, preempt=0.

## Timing
- Grant latency: req sampled high at edge N in IDLE → gnt/sel/bus_valid valid from edge N onward (visible during cycle N+1).
- Release: owner req sampled low at edge M → new gnt (or 0) valid after edge M.
  - The owner sees its gnt drop one cycle after dropping req.
  - Exactly one cycle of bus_data overlap belongs to the departing owner.
- bus_data follows wdata[sel] combinationally within the same cycle.
- Handoff has zero idle cycles between consecutive owners.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter, width $clog2(MAX_HOLD), clears on every new grant and increments each GRANT cycle.
  - When the counter equals MAX_HOLD-1 and the owner req is still high, the edge performs a forced release. Arbitration runs RR from sel+1, the owner's req is still eligible, so a sole requester is regranted.
  - preempt pulses for one cycle and the counter clears.
- Undefined:
  - No counter; an owner holds indefinitely.
  - preempt is tied to 0 and MAX_HOLD is ignored.

## Structure
- Shared package/header arb_defs contains:
  - N_REQ=4 and SEL_W=2
  - state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1
  - the reset value of last_ptr (2'd3)
- One natural sub-module is rr_pick4: a combinational rotate-priority encoder.
  - Inputs: req[3:0] and start[1:0].
  - Outputs: found and idx[1:0].
  - It is used for both IDLE arbitration and handoff.
- The FSM, last_ptr, the hold counter and the output registers live in bus_arbiter_4. The bus_data multiplexer is instantiated from the existing 4:1 mux.

## Test plan
- Reset, then req=0001: gnt=0001, sel=0 and bus_valid=1 after one edge; bus_data=wdata0=32'hAAAA_0000. Drop req0: gnt=0000 next edge, bus_data=0.
- req=1111 held, each owner drops req after 3 cycles: owners are granted in order 0,1,2,3,0 with no idle cycle between them.
- Owner 2 active with req=0101, then req2 drops: next owner is 0 (RR from 3 wraps to 0), not 1.
- rst asserted while gnt=0100: next edge gnt=0, sel=0, bus_valid=0. After rst drops with req=1010, owner is 1.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=0011 held: owner 0 for 4 cycles, preempt pulses, then owner 1 for 4 cycles. With req=0001 only, owner 0 is regranted and preempt pulses every 4 cycles.
- Without the macro, the same req=0011 stimulus: owner 0 is held for 100+ cycles and preempt stays 0.
